// File: rtl/bp_pkg.sv
// Shared types and helpers for the IF-stage branch predictor.
package bp_pkg;

  // Storage widths for in-flight entries; narrower instances zero-extend into them.
  localparam int unsigned PcMaxW  = 64;
  localparam int unsigned IdxMaxW = 16;
  localparam int unsigned CtrMaxW = 8;

  typedef struct packed {
    logic [IdxMaxW-1:0] idx;
    logic               pred;
    logic [PcMaxW-1:0]  alt_pc;
  } inflight_t;

  // Weakly not-taken: 2^(bits-1)-1.
  function automatic logic [CtrMaxW-1:0] ctr_init(input int unsigned bits);
    return CtrMaxW'((1 << (bits - 1)) - 1);
  endfunction

  // Saturating up/down step for a counter of the given width.
  function automatic logic [CtrMaxW-1:0] ctr_sat(input logic [CtrMaxW-1:0] ctr,
                                                 input int unsigned        bits,
                                                 input logic               up);
    logic [CtrMaxW-1:0] max_v;
    max_v = CtrMaxW'((1 << bits) - 1);
    if (up) return (ctr == max_v) ? ctr : ctr + 1'b1;
    else    return (ctr == '0)    ? ctr : ctr - 1'b1;
  endfunction

  // Word-aligned PC bits [idx_w+1:2]; aliasing is accepted, there are no tags.
  function automatic logic [IdxMaxW-1:0] pc_idx(input logic [PcMaxW-1:0] pc,
                                                input int unsigned       idx_w);
    logic [PcMaxW-1:0] mask;
    mask = (PcMaxW'(1) << idx_w) - 1'b1;
    return IdxMaxW'((pc >> 2) & mask);
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Circular buffer of predicted-but-unresolved branches, oldest at the head.
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  inflight_t i_entry,
  input  logic      i_pop,
  input  logic      i_flush,
  output inflight_t o_head,
  output logic      o_empty,
  output logic      o_full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  inflight_t         mem_q [Depth];
  inflight_t         mem_d [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == (PtrW + 1)'(Depth));
  assign o_head  = mem_q[rd_ptr_q];
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  // Next-state: flush discards everything; otherwise push/pop with power-of-two wrap.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = i_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    end
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/branch_pred_table.sv
// IF-stage branch predictor: per-PC saturating counters, next-PC mux, misprediction
// recovery from the in-flight FIFO, and resolved/mispredict statistics.
module branch_pred_table
  import bp_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned INFLIGHT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_br,
  input  logic             i_jal,
  input  logic [PC_W-1:0]  i_imm,
  input  logic             i_stall,
  input  logic             i_res_valid,
  input  logic             i_res_taken,
  output logic             o_pred,
  output logic             o_jump,
  output logic [PC_W-1:0]  o_pc_next,
  output logic             o_miss,
  output logic             o_full,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_miss_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'(ctr_init(CTR_BITS));

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [ENTRIES];
  logic [CNT_W-1:0]    br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] idx, head_idx;
  logic [PC_W-1:0]  pc_plus4, pc_target;
  logic             pred, resolve, miss, push, fifo_empty, unused_head;
  inflight_t        head, entry;

  assign idx       = IDX_W'(pc_idx(PcMaxW'(i_pc), IDX_W));
  assign pred      = ctr_q[idx][CTR_BITS-1];
  assign pc_plus4  = i_pc + PC_W'(4);
  assign pc_target = i_pc + i_imm;

  assign head_idx    = IDX_W'(head.idx);
  assign resolve     = i_res_valid & ~fifo_empty;
  assign miss        = resolve & (head.pred != i_res_taken);
  assign push        = i_br & ~i_stall & ~o_full & ~miss;
  assign unused_head = ^{head.idx, head.alt_pc};

  assign entry.idx    = IdxMaxW'(idx);
  assign entry.pred   = pred;
  assign entry.alt_pc = PcMaxW'(pred ? pc_plus4 : pc_target);

  // Next fetch PC: recovery beats prediction beats sequential.
  always_comb begin
    o_pred    = pred;
    o_miss    = miss;
    o_jump    = miss | i_jal | (i_br & pred);
    o_pc_next = pc_plus4;
    if (miss)                     o_pc_next = PC_W'(head.alt_pc);
    else if (i_jal || (i_br && pred)) o_pc_next = pc_target;
  end

  bp_inflight_fifo #(
    .Depth (INFLIGHT)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_entry (entry),
    .i_pop   (resolve),
    .i_flush (miss),
    .o_head  (head),
    .o_empty (fifo_empty),
    .o_full  (o_full)
  );

  // Counter training and saturating statistics on each resolution.
  always_comb begin
    ctr_d      = ctr_q;
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (resolve) begin
      ctr_d[head_idx] = CTR_BITS'(ctr_sat(CtrMaxW'(ctr_q[head_idx]), CTR_BITS, i_res_taken));
      if (br_cnt_q != '1)          br_cnt_d   = br_cnt_q + 1'b1;
      if (miss && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  // State registers, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= CtrInit;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      ctr_q      <= ctr_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign o_br_cnt   = br_cnt_q;
  assign o_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_pred_table.sv
// Directed bench for branch_pred_table (ENTRIES=64, INFLIGHT=4, CTR_BITS=2).
module tb_branch_pred_table;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc, imm;
  logic        br, jal, stall, res_valid, res_taken;
  logic        pred, jump, miss, full;
  logic [31:0] pc_next;
  logic [15:0] br_cnt, miss_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  branch_pred_table #(
    .PC_W     (32),
    .ENTRIES  (64),
    .CTR_BITS (2),
    .INFLIGHT (4),
    .CNT_W    (16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_pc        (pc),
    .i_br        (br),
    .i_jal       (jal),
    .i_imm       (imm),
    .i_stall     (stall),
    .i_res_valid (res_valid),
    .i_res_taken (res_taken),
    .o_pred      (pred),
    .o_jump      (jump),
    .o_pc_next   (pc_next),
    .o_miss      (miss),
    .o_full      (full),
    .o_br_cnt    (br_cnt),
    .o_miss_cnt  (miss_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br = 0; jal = 0; stall = 0; res_valid = 0; res_taken = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic push_br(input logic [31:0] p, input logic [31:0] im);
    pc = p; imm = im; br = 1;
    tick();
    br = 0;
  endtask

  task automatic resolve(input logic taken);
    res_valid = 1; res_taken = taken;
    tick();
    res_valid = 0; res_taken = 0;
  endtask

  task automatic run_branch(input logic [31:0] p, input logic taken);
    push_br(p, 32'h10);
    resolve(taken);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    pc = 32'h40; imm = 32'h10;
    do_reset();

    // 1. reset state and first lookup
    check("rst_miss", miss, 0);
    check("rst_full", full, 0);
    check("rst_pred", pred, 0);
    check("rst_brcnt", br_cnt, 0);
    check("rst_misscnt", miss_cnt, 0);
    br = 1;
    #1;
    check("t1_pred", pred, 0);
    check("t1_jump", jump, 0);
    check("t1_pcnext", pc_next, 32'h44);
    tick();
    br = 0;

    // 2. resolve taken -> miss, recover to alt_pc
    res_valid = 1; res_taken = 1;
    #1;
    check("t2_miss", miss, 1);
    check("t2_jump", jump, 1);
    check("t2_pcnext", pc_next, 32'h50);
    tick();
    res_valid = 1; res_taken = 0;
    #1;
    check("t2_empty_nomiss", miss, 0);
    tick();
    res_valid = 0;
    check("t2_brcnt", br_cnt, 1);
    check("t2_misscnt", miss_cnt, 1);
    pc = 32'h40; br = 1;
    #1;
    check("t2_pred_now_taken", pred, 1);
    check("t2_pcnext_taken", pc_next, 32'h50);
    br = 0;

    // jal with negative offset, and PC wraparound
    pc = 32'h80; imm = 32'hFFFF_FFF0; jal = 1;
    #1;
    check("jal_jump", jump, 1);
    check("jal_pcnext", pc_next, 32'h70);
    jal = 0; pc = 32'hFFFF_FFFC;
    #1;
    check("wrap_pcnext", pc_next, 32'h0);

    // 3. saturation and aliasing (counter[16] currently 10)
    for (int i = 0; i < 4; i++) run_branch(32'h40, 1);
    run_branch(32'h40, 0);
    pc = 32'h40; #1;
    check("t3_sat_then_dec", pred, 1);
    run_branch(32'h40, 0);
    #1;
    check("t3_dec_to_01", pred, 0);
    run_branch(32'h140, 1);
    pc = 32'h40; #1;
    check("t3_alias_shared", pred, 1);
    for (int i = 0; i < 4; i++) run_branch(32'h140, 1);
    run_branch(32'h40, 0);
    pc = 32'h140; #1;
    check("t3_alias_sat", pred, 1);
    run_branch(32'h140, 0);
    pc = 32'h40; #1;
    check("t3_alias_dec", pred, 0);

    // 4. full FIFO, dropped pushes, simultaneous push/pop
    do_reset();
    imm = 32'h20;
    push_br(32'h100, 32'h20);
    push_br(32'h104, 32'h20);
    push_br(32'h108, 32'h20);
    check("t4_not_full3", full, 0);
    push_br(32'h10C, 32'h20);
    check("t4_full", full, 1);
    push_br(32'h110, 32'h20);
    check("t4_full_after_drop", full, 1);
    pc = 32'h114; br = 1; res_valid = 1; res_taken = 0;
    #1;
    check("t4_full_same_cycle_pop", full, 1);
    check("t4_correct_nomiss", miss, 0);
    tick();
    check("t4_push_blocked_when_full", full, 0);
    pc = 32'h118;
    tick();
    check("t4_push_pop_occ3", full, 0);
    res_valid = 0; pc = 32'h11C;
    tick();
    br = 0;
    check("t4_full_again", full, 1);
    res_valid = 1; res_taken = 1;
    #1;
    check("t4_head_miss", miss, 1);
    check("t4_head_altpc", pc_next, 32'h128);
    tick();
    res_valid = 0;
    check("t4_flushed", full, 0);

    // 5. mispredict with same-cycle push flushes everything
    do_reset();
    push_br(32'h200, 32'h40);
    push_br(32'h204, 32'h40);
    push_br(32'h208, 32'h40);
    pc = 32'h20C; br = 1; res_valid = 1; res_taken = 1;
    #1;
    check("t5_miss", miss, 1);
    check("t5_pcnext", pc_next, 32'h240);
    tick();
    br = 0; res_valid = 0;
    check("t5_brcnt", br_cnt, 1);
    check("t5_misscnt", miss_cnt, 1);
    res_valid = 1; res_taken = 1;
    #1;
    check("t5_empty_nomiss", miss, 0);
    tick();
    res_valid = 0;
    check("t5_empty_brcnt", br_cnt, 1);
    check("t5_empty_misscnt", miss_cnt, 1);
    pc = 32'h200; #1;
    check("t5_head_ctr_updated", pred, 1);

    // 6. reset mid-operation
    push_br(32'h300, 32'h40);
    push_br(32'h304, 32'h40);
    push_br(32'h308, 32'h40);
    rst_n = 0;
    tick();
    rst_n = 1;
    check("t6_full", full, 0);
    check("t6_brcnt", br_cnt, 0);
    check("t6_misscnt", miss_cnt, 0);
    pc = 32'h200; #1;
    check("t6_ctr_reinit", pred, 0);
    res_valid = 1; res_taken = 1;
    #1;
    check("t6_no_miss", miss, 0);
    tick();
    res_valid = 0;

    // stall blocks push; resolution during stall still works
    pc = 32'h400; imm = 32'h8; br = 1; stall = 1;
    tick();
    stall = 0;
    tick();
    br = 0; stall = 1; res_valid = 1; res_taken = 1;
    #1;
    check("stall_resolve_miss", miss, 1);
    check("stall_resolve_pcnext", pc_next, 32'h408);
    tick();
    idle();
    check("stall_brcnt", br_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
